// File: rtl/da_pkg.sv
// -----------------------------------------------------------------------------
// da_pkg
// Shared constants and types for the bit-serial distributed-arithmetic
// accumulator (da_serial_accu) and its tag delay line (da_tag_pipe).
//   NTAPS               : number of taps feeding the DA lookup table
//   DA_COEF0..4, da_coef: tap coefficients 1, 3, 5, 7, 9
//   da_state_e          : controller states IDLE / SHIFT / DRAIN
//   DA_B_DEFAULT        : default sample width (and serial cycles per result)
//   DA_LUT_LAT_DEFAULT  : default LUT latency in clock edges
// Optional feature macro used by the design: DA_SIGNED_EN (see da_serial_accu).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package da_pkg;

  localparam int NTAPS              = 5;
  localparam int DA_B_DEFAULT       = 8;
  localparam int DA_LUT_LAT_DEFAULT = 3;

  localparam int DA_COEF0 = 1;
  localparam int DA_COEF1 = 3;
  localparam int DA_COEF2 = 5;
  localparam int DA_COEF3 = 7;
  localparam int DA_COEF4 = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } da_state_e;

  // Coefficient of a tap by index; out-of-range taps contribute nothing.
  function automatic int da_coef(input int tap);
    case (tap)
      0:       return DA_COEF0;
      1:       return DA_COEF1;
      2:       return DA_COEF2;
      3:       return DA_COEF3;
      4:       return DA_COEF4;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/da_tag_pipe.sv
// -----------------------------------------------------------------------------
// da_tag_pipe
// DEPTH-stage delay line carrying a (valid, plane index) tag alongside the
// data travelling through the DA lookup table, so the accumulator knows which
// table_out value belongs to which bit-plane.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-low reset (clears every stage)
//   in_vld  in   tag valid entering the line
//   in_idx  in   plane index entering the line
//   out_vld out  tag valid, DEPTH edges later
//   out_idx out  plane index, DEPTH edges later
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module da_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int IDXW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_vld,
  input  logic [IDXW-1:0] in_idx,
  output logic            out_vld,
  output logic [IDXW-1:0] out_idx
);

  logic            vld_reg [DEPTH];
  logic [IDXW-1:0] idx_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            vld_reg[0] <= 1'b0;
            idx_reg[0] <= '0;
          end else begin
            vld_reg[0] <= in_vld;
            idx_reg[0] <= in_idx;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            vld_reg[gi] <= 1'b0;
            idx_reg[gi] <= '0;
          end else begin
            vld_reg[gi] <= vld_reg[gi-1];
            idx_reg[gi] <= idx_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_vld = vld_reg[DEPTH-1];
  assign out_idx = idx_reg[DEPTH-1];

endmodule

// File: rtl/da_serial_accu.sv
// -----------------------------------------------------------------------------
// da_serial_accu
// Bit-serial front/back end for a 5-tap distributed-arithmetic LUT with
// coefficients 1,3,5,7,9. A sample set is accepted in parallel, presented to
// the LUT one bit-plane per cycle (LSB first), and the LUT's registered partial
// sums are shift-accumulated into y = x0 + 3x1 + 5x2 + 7x3 + 9x4.
// Parameters:
//   B       sample width; also the number of serial planes per result
//   LUT_LAT edges from a table_in update to the matching table_out update
//           (must be >= 1)
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   x_in      in   packed samples, x_i = x_in[i*B +: B]
//   x_valid   in   x_in valid
//   x_ready   out  idle, a sample set is accepted on x_valid
//   table_in  out  current bit-plane to the LUT (bit i = bit of x_i)
//   table_out in   LUT partial sum (0..25) for an earlier table_in
//   y         out  inner product, held until the next result
//   y_valid   out  one-cycle strobe for a new y
// Optional feature: define DA_SIGNED_EN for two's-complement samples; the MSB
// plane is then subtracted and y is a signed B+5-bit value.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module da_serial_accu
  import da_pkg::*;
#(
  parameter int B       = DA_B_DEFAULT,
  parameter int LUT_LAT = DA_LUT_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NTAPS*B-1:0] x_in,
  input  logic               x_valid,
  output logic               x_ready,
  output logic [NTAPS-1:0]   table_in,
  input  logic [4:0]         table_out,
  output logic [B+4:0]       y,
  output logic               y_valid
);

  localparam int YW   = B + 5;
  localparam int IDXW = (B > 1) ? $clog2(B) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(B - 1);

  da_state_e                  state_reg;
  logic [NTAPS-1:0][B-1:0]    sh_reg;
  logic [NTAPS-1:0]           table_in_reg;
  logic                       issue_vld_reg;
  logic [IDXW-1:0]            issue_idx_reg;
  logic [YW-1:0]              acc_reg;
  logic [YW-1:0]              y_reg;
  logic                       y_valid_reg;
  logic                       x_ready_reg;

  logic [NTAPS-1:0][B-1:0]    x_shift;
  logic [NTAPS-1:0][B-1:0]    sh_shift;
  logic [NTAPS-1:0]           first_plane;
  logic [NTAPS-1:0]           next_plane;
  logic                       tag_vld;
  logic [IDXW-1:0]            tag_idx;
  logic [YW-1:0]              term;
  logic [YW-1:0]              acc_next;
  logic                       last_term;
  logic                       xfer;

  // Per-tap views: plane 0 goes straight out on transfer, the remainder is
  // kept pre-shifted so bit 0 of the register is always the next plane.
  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_tap
      assign first_plane[gi] = x_in[gi*B];
      assign x_shift[gi]     = x_in[gi*B +: B] >> 1;
      assign sh_shift[gi]    = sh_reg[gi] >> 1;
      assign next_plane[gi]  = sh_reg[gi][0];
    end
  endgenerate

  // Tag follows the issued plane; the tag pipe adds LUT_LAT edges so its
  // output lines up with the table_out produced for that plane.
  da_tag_pipe #(
    .DEPTH (LUT_LAT),
    .IDXW  (IDXW)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (issue_vld_reg),
    .in_idx  (issue_idx_reg),
    .out_vld (tag_vld),
    .out_idx (tag_idx)
  );

  assign xfer      = x_valid && x_ready_reg;
  assign last_term = tag_vld && (tag_idx == IDX_LAST);

  always_comb begin
    term     = YW'(table_out) << tag_idx;
    acc_next = acc_reg;
    if (tag_vld) begin
`ifdef DA_SIGNED_EN
      // MSB plane carries negative weight in two's complement.
      if (tag_idx == IDX_LAST) begin
        acc_next = acc_reg - term;
      end else begin
        acc_next = acc_reg + term;
      end
`else
      acc_next = acc_reg + term;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      sh_reg        <= '0;
      table_in_reg  <= '0;
      issue_vld_reg <= 1'b0;
      issue_idx_reg <= '0;
      acc_reg       <= '0;
      y_reg         <= '0;
      y_valid_reg   <= 1'b0;
      x_ready_reg   <= 1'b1;
    end else begin
      y_valid_reg <= 1'b0;
      if (tag_vld) begin
        acc_reg <= acc_next;
      end

      case (state_reg)
        IDLE: begin
          if (xfer) begin
            state_reg     <= SHIFT;
            x_ready_reg   <= 1'b0;
            sh_reg        <= x_shift;
            table_in_reg  <= first_plane;
            issue_vld_reg <= 1'b1;
            issue_idx_reg <= '0;
            acc_reg       <= '0;
          end
        end

        SHIFT: begin
          if (issue_idx_reg == IDX_LAST) begin
            // All planes issued; park table_in at zero while the LUT drains.
            state_reg     <= DRAIN;
            table_in_reg  <= '0;
            issue_vld_reg <= 1'b0;
          end else begin
            sh_reg        <= sh_shift;
            table_in_reg  <= next_plane;
            issue_idx_reg <= issue_idx_reg + 1'b1;
          end
        end

        DRAIN: begin
          // The final term is folded in on the same edge that publishes y.
          if (last_term) begin
            y_reg       <= acc_next;
            y_valid_reg <= 1'b1;
            x_ready_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign x_ready  = x_ready_reg;
  assign table_in = table_in_reg;
  assign y        = y_reg;
  assign y_valid  = y_valid_reg;

endmodule

// File: tb/tb_da_serial_accu.sv
`timescale 1ns/1ps
module tb_da_serial_accu;
  import da_pkg::*;

  localparam int B       = 8;
  localparam int LUT_LAT = 3;
  localparam int YW      = B + 5;
  localparam int LAT     = B + LUT_LAT;   // edges from transfer to result

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [5*B-1:0]    x_in = '0;
  logic              x_valid = 1'b0;
  logic              x_ready;
  logic [4:0]        table_in;
  logic [4:0]        table_out;
  logic [YW-1:0]     y;
  logic              y_valid;

  int n_checks = 0;
  int n_errors = 0;
  longint prev_y = 0;

  always #5 clk = ~clk;

  da_serial_accu #(.B(B), .LUT_LAT(LUT_LAT)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .table_in  (table_in),
    .table_out (table_out),
    .y         (y),
    .y_valid   (y_valid)
  );

  // LUT stand-in: three registered stages, reset to a nonzero junk value.
  logic [4:0] lut_s1, lut_s2;
  function automatic logic [4:0] lut_f(input logic [4:0] tin);
    int s = 0;
    for (int i = 0; i < 5; i++) if (tin[i]) s += da_coef(i);
    return 5'(s);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_s1    <= 5'd23;
      lut_s2    <= 5'd23;
      table_out <= 5'd23;
    end else begin
      lut_s1    <= lut_f(table_in);
      lut_s2    <= lut_s1;
      table_out <= lut_s2;
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5*B-1:0] pack5(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3,
                                           input logic [7:0] a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  // Reference: plain weighted sum of the samples.
  function automatic longint model_y(input logic [5*B-1:0] xv);
    longint s = 0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0]        u;
      logic signed [7:0] sv;
      longint            v;
      u  = xv[i*B +: B];
      sv = u;
`ifdef DA_SIGNED_EN
      v = longint'(sv);
`else
      v = longint'(u);
`endif
      s += longint'(da_coef(i)) * v;
    end
    return s;
  endfunction

  function automatic logic [4:0] plane(input logic [5*B-1:0] xv, input int k);
    logic [4:0] p;
    for (int i = 0; i < 5; i++) p[i] = xv[i*B + k];
    return p;
  endfunction

  function automatic longint y_obs();
    logic signed [YW-1:0] s;
    s = y;
`ifdef DA_SIGNED_EN
    return longint'(s);
`else
    return longint'(y);
`endif
  endfunction

  // One transaction: offer xv, follow it edge by edge to its result.
  // cont=1 keeps x_valid high with next_xv so the next set goes in back-to-back.
  task automatic do_op(input logic [5*B-1:0] xv, input bit cont, input logic [5*B-1:0] next_xv);
    longint    exp_y;
    int        waited;
    logic [63:0] r;
    exp_y  = model_y(xv);
    waited = 0;
    while (x_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("ready_before_xfer", longint'(x_ready), 1);
    x_in    = xv;
    x_valid = 1'b1;
    @(posedge clk); #1;   // transfer edge e0
    for (int e = 0; e <= LAT; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      if (cont) begin
        x_valid = 1'b1;
        x_in    = next_xv;
      end else if (e < LAT) begin
        r       = {$urandom, $urandom};
        x_valid = 1'($urandom_range(0, 1));
        x_in    = r[5*B-1:0];
      end else begin
        x_valid = 1'b0;
      end
      if (e < B) check_eq($sformatf("table_in_p%0d", e), longint'(table_in), longint'(plane(xv, e)));
      else       check_eq("table_in_idle", longint'(table_in), 0);
      if (e < LAT) begin
        check_eq("y_valid_low", longint'(y_valid), 0);
        check_eq("x_ready_busy", longint'(x_ready), 0);
        if (e == 0) check_eq("y_hold_prev", y_obs(), prev_y);
      end else begin
        check_eq("y_valid_high", longint'(y_valid), 1);
        check_eq("y_value", y_obs(), exp_y);
        check_eq("x_ready_done", longint'(x_ready), 1);
      end
    end
    $display("op x=%h y=%0d exp=%0d cont=%0d", xv, y_obs(), exp_y, cont);
    prev_y = exp_y;
    if (!cont) begin
      @(posedge clk); #1;
      check_eq("y_valid_strobe", longint'(y_valid), 0);
      check_eq("y_hold", y_obs(), prev_y);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_x_ready"}, longint'(x_ready), 1);
    check_eq({tag, "_table_in"}, longint'(table_in), 0);
    check_eq({tag, "_y"}, longint'(y), 0);
    check_eq({tag, "_y_valid"}, longint'(y_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5*B-1:0] cur, nxt;
    logic [63:0]    r;
    bit             c;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(pack5(8'd1, 8'd1, 8'd1, 8'd1, 8'd1), 1'b0, '0);
    do_op(pack5(8'd10, 8'd20, 8'd30, 8'd40, 8'd50), 1'b1, pack5(8'd255, 8'd255, 8'd255, 8'd255, 8'd255));
    do_op(pack5(8'd255, 8'd255, 8'd255, 8'd255, 8'd255), 1'b0, '0);
    do_op(pack5(8'd0, 8'd0, 8'd0, 8'd0, 8'd200), 1'b0, '0);
    do_op(pack5(8'd1, 8'd0, 8'd0, 8'd0, 8'd0), 1'b0, '0);
    do_op(pack5(8'h80, 8'd0, 8'd0, 8'd0, 8'h7F), 1'b0, '0);

    // Reset in the middle of a serial pass.
    x_in    = pack5(8'd77, 8'd66, 8'd55, 8'd44, 8'd33);
    x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    prev_y = 0;
    begin
      int strobes = 0;
      for (int i = 0; i < LAT + 4; i++) begin
        @(posedge clk); #1;
        if (y_valid) strobes++;
      end
      check_eq("no_strobe_after_reset", longint'(strobes), 0);
    end
    do_op(pack5(8'd2, 8'd2, 8'd2, 8'd2, 8'd2), 1'b0, '0);

    // Randomized sets, some back-to-back.
    r   = {$urandom, $urandom};
    cur = r[5*B-1:0];
    for (int n = 0; n < 12; n++) begin
      r   = {$urandom, $urandom};
      nxt = r[5*B-1:0];
      c   = 1'($urandom_range(0, 1));
      do_op(cur, c, nxt);
      cur = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/da_serial_accu.md
Name: da_serial_accu

Overview:
- Bit-serial distributed-arithmetic front/back end for the 5-tap DA lookup table with coefficients 1, 3, 5, 7 and 9.
- Accepts five parallel B-bit samples and drives one bit-plane per cycle, LSB first, onto the LUT's 5-bit table_in.
- Consumes the LUT's registered 5-bit partial sums (0..25) and shift-accumulates them into the full inner product y = 1·x0 + 3·x1 + 5·x2 + 7·x3 + 9·x4.

Parameters:
- B, 8: sample width in bits; also the number of serial cycles per result.
- LUT_LAT, 3: number of clock edges from the edge at which this block updates table_in to the edge at which the LUT updates the matching table_out.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-low reset.
- x_in  in  5*B: packed samples; x_i = x_in[i*B +: B], i = 0..4.
- x_valid  in  1: x_in is valid.
- x_ready  out  1: block is idle and accepts a sample set.
- table_in  out  5: bit-plane to the LUT; table_in[i] = current bit of x_i.
- table_out  in  5: LUT partial sum (0..25) for an earlier table_in.
- y  out  B+5: inner-product result.
- y_valid  out  1: one-cycle strobe marking a new y.

Behaviour:
- Reset (async assert, any state): state=IDLE, x_ready=1, table_in=0, y=0, y_valid=0, accumulator=0, tag pipeline=0. An operation in progress is discarded with no y_valid.
- Handshake: transfer on a rising edge with x_valid && x_ready. x_valid while x_ready=0 is ignored; no buffering.
- FSM:
  - IDLE -> SHIFT on transfer.
  - SHIFT -> DRAIN after B bit-planes have been issued.
  - DRAIN -> IDLE after the last tagged partial sum is accumulated.
- Issue, transfer at edge e0: shift registers load x_in. table_in <= bit 0 of each x_i at e0, then bit k at edge e0+k for k = 0..B-1. table_in <= 0 at e0+B. x_ready=0 from e0 until completion.
- Tagging: a (valid, k) tag enters a LUT_LAT-deep delay line with each issued plane. The table_out for plane k is sampled at edge e0+k+LUT_LAT+1 and added as table_out << k. The accumulator is cleared at e0.
- Completion at edge e0+B+LUT_LAT:
  - y <= final sum, including the last term in the same edge.
  - y_valid <= 1 for exactly one cycle.
  - x_ready <= 1 and state=IDLE.
  - The earliest next transfer is e0+B+LUT_LAT+1.
  - Default parameters give a result 11 edges after transfer.
- Width: unsigned. The maximum is 25·(2^B−1), which fits B+5 bits with no overflow. y holds its value until the next completion.
- Untagged table_out values are never accumulated, including the LUT's reset and garbage values.

Optional Feature:
- Macro DA_SIGNED_EN.
- Defined:
  - x_i are two's-complement.
  - The plane k = B−1 partial sum is subtracted: acc − (table_out << (B−1)).
  - y is signed B+5 bits, range −25·2^(B−1) .. 25·(2^(B−1)−1).
- Undefined: all samples and y are unsigned, as above.

Decomposition:
- Package da_pkg holds:
  - NTAPS=5;
  - coefficient constants 1, 3, 5, 7, 9, used by the bench's reference model;
  - the state enum {IDLE, SHIFT, DRAIN};
  - the default B and LUT_LAT.
- One natural sub-module: da_tag_pipe, the LUT_LAT-deep valid/index delay line.
- The bit-serial shift registers and accumulator stay in the top.

Test Plan:
- Bench instantiates this block connected to the 5-tap LUT. B=8.
- x = (1,1,1,1,1) -> y=25; y_valid high only at the 11th edge after transfer; table_in=5'b11111 only on the first plane.
- x = (10,20,30,40,50) -> y=950. Back-to-back: x=(255,255,255,255,255) offered continuously -> y=6375, accepted at e0+12.
- x = (0,0,0,0,200) -> y=1800. Then (1,0,0,0,0) -> y=1. x_valid toggled during SHIFT has no effect and x_ready stays 0.
- reset asserted at edge e0+5 mid-SHIFT -> outputs return to reset values immediately with no y_valid. A new set (2,2,2,2,2) after release -> y=50.
- DA_SIGNED_EN, x all 8'hFF (−1) -> y=−25. x=(−128,0,0,0,127) -> y=1015.
